// File: rtl/bist_fail_log.sv
// bist_fail_log: logs March-test read mismatches into a FIFO and summarises the run. Rev 1.0.
// Optional first-fail capture is enabled by defining BIST_FIRST_FAIL_EN.
`default_nettype none

module bist_fail_log #(
  parameter int Dta_size  = 8,
  parameter int Adr_size  = 4,
  parameter int LOG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                test_start,
  input  logic                test_end,
  input  logic [2:0]          phase,
  input  logic                read_en,
  input  logic [Adr_size-1:0] address,
  input  logic [Dta_size-1:0] data_et,
  input  logic [Dta_size-1:0] data_read,
  output logic                log_valid,
  input  logic                log_ready,
  output logic [Adr_size-1:0] log_adr,
  output logic [2:0]          log_phase,
  output logic [Dta_size-1:0] log_syn,
  output logic [7:0]          err_count,
  output logic                overflow,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                first_vld,
  output logic [Adr_size-1:0] first_adr,
  output logic [2:0]          first_phase
);

  localparam int PW = $clog2(LOG_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic [Adr_size-1:0] mem_adr [LOG_DEPTH];
  logic [2:0]          mem_phase [LOG_DEPTH];
  logic [Dta_size-1:0] mem_syn [LOG_DEPTH];

  logic mismatch, full, pop, push, drop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, REPORT: if (test_start) state_nxt = ARMED;
      ARMED: begin
        if (test_start)    state_nxt = ARMED;
        else if (test_end) state_nxt = REPORT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign busy = (state == ARMED);
  assign done = (state == REPORT);
  assign pass = done && (err_count == 8'd0);

  // A compare coinciding with test_start belongs to the run being discarded.
  assign mismatch  = busy && read_en && !test_start && (data_et != data_read);
  assign log_valid = (count != '0);
  assign full      = (count == (PW+1)'(LOG_DEPTH));
  assign pop       = log_valid && log_ready && !test_start;
  assign push      = mismatch && (!full || pop);
  assign drop      = mismatch && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst || test_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
      if (mismatch && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wr_ptr]   <= address;
      mem_phase[wr_ptr] <= phase;
      mem_syn[wr_ptr]   <= data_et ^ data_read;
    end
  end

  assign log_adr   = log_valid ? mem_adr[rd_ptr]   : '0;
  assign log_phase = log_valid ? mem_phase[rd_ptr] : 3'd0;
  assign log_syn   = log_valid ? mem_syn[rd_ptr]   : '0;

`ifdef BIST_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!rst || test_start) begin
      first_vld   <= 1'b0;
      first_adr   <= '0;
      first_phase <= 3'd0;
    end else if (mismatch && !first_vld) begin
      first_vld   <= 1'b1;
      first_adr   <= address;
      first_phase <= phase;
    end
  end
`else
  assign first_vld   = 1'b0;
  assign first_adr   = '0;
  assign first_phase = 3'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bist_fail_log.sv
// tb_bist_fail_log: scoreboard bench for bist_fail_log (default parameters).
`default_nettype none

module tb_bist_fail_log;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       test_start = 1'b0, test_end = 1'b0, read_en = 1'b0, log_ready = 1'b0;
  logic [2:0] phase = 3'd0;
  logic [3:0] address = 4'd0;
  logic [7:0] data_et = 8'd0, data_read = 8'd0;
  logic       log_valid, overflow, busy, done, pass, first_vld;
  logic [3:0] log_adr, first_adr;
  logic [2:0] log_phase, first_phase;
  logic [7:0] log_syn, err_count;

  int total = 0;
  int bad = 0;
  logic [14:0] q[$];
  int          exp_err = 0;
  logic        exp_ovf = 1'b0;
  int          mstate = 0;

  bist_fail_log dut (
    .clk(clk), .rst(rst), .test_start(test_start), .test_end(test_end),
    .phase(phase), .read_en(read_en), .address(address), .data_et(data_et),
    .data_read(data_read), .log_valid(log_valid), .log_ready(log_ready),
    .log_adr(log_adr), .log_phase(log_phase), .log_syn(log_syn),
    .err_count(err_count), .overflow(overflow), .busy(busy), .done(done),
    .pass(pass), .first_vld(first_vld), .first_adr(first_adr),
    .first_phase(first_phase)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted head entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && log_valid && log_ready) begin
      logic [14:0] e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %h expected no entry", {log_adr, log_phase, log_syn});
      end else begin
        e = q.pop_front();
        if ({log_adr, log_phase, log_syn} !== e) begin
          bad++;
          $display("FAIL pop_entry: got %h expected %h", {log_adr, log_phase, log_syn}, e);
        end
      end
    end
  end

  task automatic drive(input logic ts, input logic te, input logic re, input logic [3:0] a,
                       input logic [2:0] ph, input logic [7:0] et, input logic [7:0] rd,
                       input logic rdy);
    test_start = ts; test_end = te; read_en = re; address = a;
    phase = ph; data_et = et; data_read = rd; log_ready = rdy;
    if (ts) begin
      q.delete(); exp_err = 0; exp_ovf = 1'b0; mstate = 1;
    end else if (mstate == 1) begin
      if (re && (et != rd)) begin
        if (exp_err != 255) exp_err++;
        if (q.size() < 4 || rdy) q.push_back({a, ph, et ^ rd});
        else exp_ovf = 1'b1;
      end
      if (te) mstate = 2;
    end
    @(posedge clk); #1;
    test_start = 1'b0; test_end = 1'b0; read_en = 1'b0; log_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; q.delete(); exp_err = 0; exp_ovf = 1'b0; mstate = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({log_valid, err_count, overflow, busy, done, pass, first_vld, first_adr, first_phase,
         log_adr, log_phase, log_syn} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected all zero", {log_valid, err_count, overflow,
               busy, done, pass, first_vld, first_adr, first_phase, log_adr, log_phase, log_syn});
    end
  endtask

  task automatic test_clean();
    logic [7:0] d;
    drive(1, 0, 0, 0, 3'b010, 0, 0, 0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL clean_busy: got %b expected 1", busy); end
    for (int i = 0; i < 64; i++) begin
      d = 8'($urandom);
      drive(0, 0, 1, 4'(i), 3'b011, d, d, 0);
    end
    drive(0, 1, 0, 0, 3'b101, 0, 0, 0);
    total++;
    if ({done, pass, busy, log_valid, err_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL clean_result: got done=%b pass=%b busy=%b valid=%b err=%0d expected 1 1 0 0 0",
               done, pass, busy, log_valid, err_count);
    end
  endtask

  task automatic test_single_fail();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 4'h5, 3'b011, 8'hFF, 8'hFB, 0);
    total++;
    if ({log_valid, log_adr, log_phase, log_syn, err_count} !== {1'b1, 4'h5, 3'b011, 8'h04, 8'd1}) begin
      bad++;
      $display("FAIL single_entry: got v=%b a=%h p=%b s=%h err=%0d expected 1 5 011 04 1",
               log_valid, log_adr, log_phase, log_syn, err_count);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    total++;
    if ({done, pass} !== 2'b10) begin
      bad++; $display("FAIL single_pass: got done=%b pass=%b expected 1 0", done, pass);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    total++;
    if (log_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b expected 0", log_valid); end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 4'(i + 1), 3'b100, 8'h00, 8'(1 << i), 0);
    total++;
    if ({err_count, overflow, log_adr} !== {8'd6, 1'b1, 4'd1}) begin
      bad++;
      $display("FAIL ovf_state: got err=%0d ovf=%b head=%h expected 6 1 1", err_count, overflow, log_adr);
    end
    total++;
    if (q.size() != 4 || q[3][14:11] != 4'd4) begin
      bad++; $display("FAIL ovf_model: got depth %0d expected 4", q.size());
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
    total++;
    if ({log_valid, overflow} !== 2'b01) begin
      bad++; $display("FAIL ovf_sticky: got valid=%b ovf=%b expected 0 1", log_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 4'(i + 1), 3'b011, 8'hAA, 8'hAB, 0);
    drive(0, 0, 1, 4'h9, 3'b101, 8'h0F, 8'hF0, 1);
    total++;
    if ({overflow, log_valid, log_adr, err_count} !== {1'b0, 1'b1, 4'd2, 8'd5}) begin
      bad++;
      $display("FAIL fullpop_state: got ovf=%b v=%b head=%h err=%0d expected 0 1 2 5",
               overflow, log_valid, log_adr, err_count);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
    total++;
    if (log_valid !== 1'b0 || q.size() != 0) begin
      bad++; $display("FAIL fullpop_drain: got valid=%b left=%0d expected 0 0", log_valid, q.size());
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 4'h2, 3'b010, 8'h11, 8'h10, 0);
    drive(0, 0, 1, 4'h3, 3'b010, 8'h11, 8'h12, 0);
    do_reset();
    total++;
    if ({log_valid, err_count, busy, done, pass, first_vld, log_adr, log_syn} !== '0) begin
      bad++;
      $display("FAIL midreset: got v=%b err=%0d busy=%b done=%b expected all 0",
               log_valid, err_count, busy, done);
    end
    drive(0, 0, 1, 4'h4, 3'b011, 8'h01, 8'h02, 0);
    total++;
    if ({log_valid, err_count, busy} !== '0) begin
      bad++; $display("FAIL idle_ignored: got v=%b err=%0d busy=%b expected 0", log_valid, err_count, busy);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 4'h6, 3'b011, 8'h01, 8'h02, 0);
    drive(1, 1, 1, 4'h7, 3'b011, 8'h01, 8'h02, 0);
    total++;
    if ({busy, done, log_valid, err_count, overflow} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL restart: got busy=%b done=%b v=%b err=%0d expected 1 0 0 0",
               busy, done, log_valid, err_count);
    end
  endtask

  task automatic test_end_fail();
    drive(0, 1, 1, 4'h7, 3'b101, 8'h80, 8'h00, 0);
    total++;
    if ({done, pass, err_count, log_valid, log_adr, log_syn} !== {1'b1, 1'b0, 8'd1, 1'b1, 4'h7, 8'h80}) begin
      bad++;
      $display("FAIL end_fail: got done=%b pass=%b err=%0d v=%b a=%h s=%h expected 1 0 1 1 7 80",
               done, pass, err_count, log_valid, log_adr, log_syn);
    end
    drive(0, 0, 1, 4'h8, 3'b101, 8'h80, 8'h00, 1);
    total++;
    if ({err_count, log_valid} !== {8'd1, 1'b0}) begin
      bad++; $display("FAIL report_ignored: got err=%0d v=%b expected 1 0", err_count, log_valid);
    end
  endtask

  task automatic test_first_fail();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 4'h3, 3'b011, 8'h55, 8'h54, 0);
    drive(0, 0, 1, 4'h9, 3'b100, 8'h55, 8'h56, 0);
    total++;
`ifdef BIST_FIRST_FAIL_EN
    if ({first_vld, first_adr, first_phase} !== {1'b1, 4'h3, 3'b011}) begin
      bad++;
      $display("FAIL first_fail: got v=%b a=%h p=%b expected 1 3 011", first_vld, first_adr, first_phase);
    end
`else
    if ({first_vld, first_adr, first_phase} !== '0) begin
      bad++;
      $display("FAIL first_fail_off: got v=%b a=%h p=%b expected 0 0 0", first_vld, first_adr, first_phase);
    end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (first_vld !== 1'b0) begin bad++; $display("FAIL first_clear: got %b expected 0", first_vld); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) drive(0, 0, 1, 4'(i), 3'b010, 8'(i), 8'(i) ^ 8'h01, 1);
    total++;
    if (err_count !== 8'd255 || exp_err != 255) begin
      bad++; $display("FAIL saturate: got %0d expected 255", err_count);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 1);
    total++;
    if ({log_valid, overflow, done} !== {1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sat_end: got v=%b ovf=%b done=%b expected 0 0 1", log_valid, overflow, done);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_fail();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_end_fail();
    test_first_fail();
    test_saturate();
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL leftover: got %0d entries expected 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/bist_fail_log.md
BIST_FAIL_LOG -- requirements
Module: bist_fail_log

Interface
REQ-001 Parameter Dta_size, default 8: memory data width in bits.
REQ-002 Parameter Adr_size, default 4: memory address width in bits.
REQ-003 Parameter LOG_DEPTH, default 4: number of fail-log entries; power of two, at least 2.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 test_start  input  1: one-cycle pulse from the BIST controller when a March run begins.
REQ-007 test_end  input  1: one-cycle pulse when the controller returns to standby after read_up.
REQ-008 phase  input  3: controller state code (010 wr_up, 011 read_down, 100 wr_down, 101 read_up).
REQ-009 read_en  input  1: controller read strobe; a compare is valid only while it is 1.
REQ-010 address  input  Adr_size: address currently applied to memory.
REQ-011 data_et  input  Dta_size: expected (etalon) data from the data generator.
REQ-012 data_read  input  Dta_size: data returned by memory.
REQ-013 log_valid  output  1: log head entry available.
REQ-014 log_ready  input  1: consumer accepts the head entry when log_valid & log_ready.
REQ-015 log_adr / log_phase / log_syn  output  Adr_size / 3 / Dta_size: head entry address, phase, syndrome (data_et XOR data_read).
REQ-016 err_count  output  8: number of mismatches in the current run, saturating.
REQ-017 overflow  output  1: sticky; a mismatch was dropped because the log was full.
REQ-018 busy / done / pass  output  1 each: run in progress / run finished / finished with err_count==0.
REQ-019 first_vld, first_adr, first_phase  output  1, Adr_size, 3: first-fail capture (see Configuration).

Function
REQ-020 FSM states: IDLE, ARMED, REPORT; busy=1 only in ARMED; done=1 only in REPORT; pass = done & (err_count==0).
REQ-021 IDLE/REPORT + test_start -> ARMED, and log, err_count, overflow and first-fail registers clear in that same edge.
REQ-022 ARMED + test_start -> stays ARMED with all results cleared (restart); test_start has priority over test_end.
REQ-023 ARMED + test_end -> REPORT; REPORT holds until test_start or reset.
REQ-024 A mismatch is an edge in ARMED with read_en=1 and data_et != data_read; nothing is logged in IDLE or REPORT.
REQ-025 On a mismatch: err_count increments (saturates at 255), and {address, phase, syndrome} is pushed; log_valid rises one cycle after the mismatch edge when the log was empty.
REQ-026 A mismatch coinciding with test_end is logged and counted before entering REPORT.
REQ-027 Log is a FIFO of LOG_DEPTH entries; pop on log_valid & log_ready, legal in ARMED and REPORT.
REQ-028 Full log + mismatch without pop: entry dropped, overflow set, err_count still increments.
REQ-029 Full log + mismatch + pop in the same cycle: head popped and new entry accepted; overflow unchanged.
REQ-030 Empty log: log_valid=0; log_ready ignored; pointers wrap modulo LOG_DEPTH.

Reset
REQ-031 rst=0 at a rising edge: state IDLE, log empty, log_valid=0, err_count=0, overflow=0, busy=0, done=0, pass=0, first_vld=0, first_adr=0, first_phase=0; log_adr/log_phase/log_syn=0.
REQ-032 Reset asserted mid-run discards all results; test_start is required to re-arm.

Configuration
REQ-033 Macro BIST_FIRST_FAIL_EN defined: on the first mismatch of a run, first_vld=1 and first_adr/first_phase capture that mismatch and hold until cleared by test_start or reset, independent of log overflow.
REQ-034 BIST_FIRST_FAIL_EN undefined: first_vld, first_adr and first_phase are constant 0 and no capture registers exist; all other behaviour is unchanged.

Verification
REQ-035 Clean run: test_start, 64 read_en cycles with data_et==data_read, test_end -> done=1, pass=1, err_count=0, log_valid=0.
REQ-036 Single fail: phase=011, address=4'h5, data_et=8'hFF, data_read=8'hFB -> next cycle log_valid=1, log_adr=5, log_phase=011, log_syn=8'h04; err_count=1; after test_end pass=0.
REQ-037 Overflow: 6 mismatches with log_ready=0, LOG_DEPTH=4 -> err_count=6, overflow=1, log holds the first 4 addresses in order.
REQ-038 Full log + simultaneous pop and mismatch -> 4 entries remain, overflow=0, new entry is at the tail.
REQ-039 Reset: rst=0 for one cycle during ARMED with 2 entries logged -> all outputs at their REQ-031 values the next cycle; test_start and test_end in the same cycle in ARMED -> stays ARMED with results cleared.
REQ-040 With BIST_FIRST_FAIL_EN: mismatches at addresses 3 then 9 -> first_vld=1, first_adr=3; without the macro -> first_vld=0 throughout.
